// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters, with bounded bursts.
// Optional per-requester grant counters are compiled in when SP_RAM_ARB_STATS_EN is defined.
module sp_ram_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_dout,
`ifdef SP_RAM_ARB_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       gnt0_cnt,
  output logic [15:0]       gnt1_cnt,
`endif
  output logic [1:0]        dbg_state
);

  // Handshake: a command moves on a cycle where reqN_valid and reqN_ready are both high;
  // ready is only raised for a valid requester, and commands are held stable until accepted.

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  burst_cnt_q;
  logic              rr_next_q;
  logic              rd_pend_q;
  logic              rd_id_q;

  logic              gnt_vld;
  logic              gnt_id;
  logic              burst_open;
  logic              same_owner;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  state_t            state_d;
  logic [CNT_W-1:0]  burst_cnt_d;

  assign burst_open = (burst_cnt_q < BURST_MAX);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    case (state_q)
      OWN0: begin
        if (req0_valid && (!req1_valid || burst_open)) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b0;
        end else if (req1_valid) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
        end
      end
      OWN1: begin
        if (req1_valid && (!req0_valid || burst_open)) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
        end else if (req0_valid) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b0;
        end
      end
      IDLE: begin
        if (req0_valid && req1_valid) begin
          gnt_vld = 1'b1;
          gnt_id  = rr_next_q;
        end else if (req0_valid) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b0;
        end else if (req1_valid) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
        end
      end
      default: begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
      end
    endcase
    // Outputs must stay quiet for the whole reset window, not just after the first edge.
    if (!rst_n) gnt_vld = 1'b0;
  end

  assign win_we    = gnt_id ? req1_we    : req0_we;
  assign win_addr  = gnt_id ? req1_addr  : req0_addr;
  assign win_wdata = gnt_id ? req1_wdata : req0_wdata;

  assign req0_ready = gnt_vld & ~gnt_id;
  assign req1_ready = gnt_vld &  gnt_id;

  assign ram_en   = gnt_vld;
  assign ram_we   = gnt_vld & win_we;
  assign ram_addr = gnt_vld ? win_addr  : '0;
  assign ram_di   = gnt_vld ? win_wdata : '0;

  assign same_owner = gnt_id ? (state_q == OWN1) : (state_q == OWN0);

  always_comb begin
    state_d     = IDLE;
    burst_cnt_d = '0;
    if (gnt_vld) begin
      state_d = gnt_id ? OWN1 : OWN0;
      if (!same_owner)
        burst_cnt_d = CNT_W'(1);
      else if (burst_cnt_q == BURST_MAX)
        burst_cnt_d = burst_cnt_q;
      else
        burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      rr_next_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_id_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      if (gnt_vld) rr_next_q <= ~gnt_id;
      rd_pend_q   <= gnt_vld & ~win_we;
      rd_id_q     <= gnt_id;
    end
  end

  // Read data arrives from the RAM one cycle after the accept; steer it to the tagged requester.
  assign rsp0_valid = rd_pend_q & ~rd_id_q;
  assign rsp1_valid = rd_pend_q &  rd_id_q;
  assign rsp0_rdata = rsp0_valid ? ram_dout : '0;
  assign rsp1_rdata = rsp1_valid ? ram_dout : '0;

  assign dbg_state = state_q;

`ifdef SP_RAM_ARB_STATS_EN
  logic [15:0] gnt0_cnt_q;
  logic [15:0] gnt1_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_cnt_q <= '0;
      gnt1_cnt_q <= '0;
    end else if (stats_clr) begin
      gnt0_cnt_q <= '0;
      gnt1_cnt_q <= '0;
    end else begin
      if (req0_ready && gnt0_cnt_q != 16'hFFFF) gnt0_cnt_q <= gnt0_cnt_q + 16'd1;
      if (req1_ready && gnt1_cnt_q != 16'hFFFF) gnt1_cnt_q <= gnt1_cnt_q + 16'd1;
    end
  end

  assign gnt0_cnt = gnt0_cnt_q;
  assign gnt1_cnt = gnt1_cnt_q;
`endif

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with a behavioural 1Kx16 registered-read RAM model.
// Counter checks are compiled in when SP_RAM_ARB_STATS_EN is defined.
module tb_sp_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_we;
  logic [9:0]  req0_addr;
  logic [15:0] req0_wdata;
  logic        rsp0_valid;
  logic [15:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [9:0]  req1_addr;
  logic [15:0] req1_wdata;
  logic        rsp1_valid;
  logic [15:0] rsp1_rdata;
  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [15:0] ram_di;
  logic [15:0] ram_dout;
  logic [1:0]  dbg_state;
`ifdef SP_RAM_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] gnt0_cnt, gnt1_cnt;
`endif

  int n_checks;
  int n_err;

  sp_ram_arbiter #(.ADDR_W(10), .DATA_W(16), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_di     (ram_di),
    .ram_dout   (ram_dout),
`ifdef SP_RAM_ARB_STATS_EN
    .stats_clr  (stats_clr),
    .gnt0_cnt   (gnt0_cnt),
    .gnt1_cnt   (gnt1_cnt),
`endif
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read, dout holds when disabled or writing
  logic [15:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      else        ram_dout      <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: apply inputs on the falling edge, settle before checks
  task automatic set_in(input logic v0, input logic w0, input logic [9:0] a0, input logic [15:0] d0,
                        input logic v1, input logic w1, input logic [9:0] a1, input logic [15:0] d1);
    @(negedge clk);
    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 10'h0, 16'h0, 1'b0, 1'b0, 10'h0, 16'h0);
  endtask

  logic [19:0] pat;
  int b0, b1;

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
`ifdef SP_RAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif

    // Outputs held at zero during reset even with both requesters valid
    set_in(1'b1, 1'b1, 10'h3, 16'hFFFF, 1'b1, 1'b0, 10'h7, 16'h0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_di", ram_di, 0);
    chk("rst_rsp0", rsp0_valid, 0);
    chk("rst_rsp1", rsp1_valid, 0);
    chk("rst_state", dbg_state, 0);

    // Preload 0x010 / 0x020 through requester 0
    set_in(1'b1, 1'b1, 10'h010, 16'hAAAA, 1'b0, 1'b0, 10'h0, 16'h0);
    rst_n = 1'b1;
    #1;
    chk("pre_ready0", req0_ready, 1);
    chk("pre_ram_we", ram_we, 1);
    set_in(1'b1, 1'b1, 10'h020, 16'h5555, 1'b0, 1'b0, 10'h0, 16'h0);
    chk("pre_ram_di", ram_di, 16'h5555);
    idle();
    chk("pre_no_rsp", rsp0_valid, 0);

    // Second reset clears rr_next (last accept was requester 0)
    rst_n = 1'b0;
    idle();
    set_in(1'b1, 1'b0, 10'h010, 16'h0, 1'b1, 1'b0, 10'h020, 16'h0);
    rst_n = 1'b1;
    #1;
    chk("both_ready0", req0_ready, 1);
    chk("both_ready1", req1_ready, 0);
    chk("both_addr0", ram_addr, 10'h010);
    chk("both_ram_we", ram_we, 0);
    set_in(1'b0, 1'b0, 10'h0, 16'h0, 1'b1, 1'b0, 10'h020, 16'h0);
    chk("both_ready1b", req1_ready, 1);
    chk("both_addr1", ram_addr, 10'h020);
    chk("both_rsp0_v", rsp0_valid, 1);
    chk("both_rsp0_d", rsp0_rdata, 16'hAAAA);
    chk("both_rsp1_v0", rsp1_valid, 0);
    idle();
    chk("both_rsp1_v", rsp1_valid, 1);
    chk("both_rsp1_d", rsp1_rdata, 16'h5555);
    chk("both_rsp0_off", rsp0_valid, 0);
    chk("both_idle_en", ram_en, 0);
    idle();
    chk("both_state", dbg_state, 0);
    chk("both_rsp1_d0", rsp1_rdata, 0);

    // Contended bursts: 10 writes each, MAX_BURST=4
    pat = 20'b0000_1111_0000_1111_0011;
    b0 = 0;
    b1 = 0;
    for (int c = 0; c < 20; c++) begin
      set_in(b0 < 10, 1'b1, 10'h100 + 10'(b0), 16'hA000 + 16'(b0),
             b1 < 10, 1'b1, 10'h200 + 10'(b1), 16'hB000 + 16'(b1));
      chk("burst_gnt0", req0_ready, !pat[19-c]);
      chk("burst_gnt1", req1_ready, pat[19-c]);
      if (req0_ready) b0++;
      if (req1_ready) b1++;
    end
    chk("burst_beats0", b0, 10);
    chk("burst_beats1", b1, 10);

    // Requester 1 alone: 8 back-to-back pipelined reads of its burst data
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 1'b0, 10'h0, 16'h0, 1'b1, 1'b0, 10'h200 + 10'(i), 16'h0);
      chk("solo_ready1", req1_ready, 1);
      chk("solo_addr", ram_addr, 10'h200 + 10'(i));
      if (i > 0) begin
        chk("solo_rsp1_v", rsp1_valid, 1);
        chk("solo_rsp1_d", rsp1_rdata, 16'hB000 + 16'(i - 1));
      end else begin
        chk("solo_rsp1_first", rsp1_valid, 0);
      end
    end
    idle();
    chk("solo_last_v", rsp1_valid, 1);
    chk("solo_last_d", rsp1_rdata, 16'hB007);
    chk("solo_idle_en", ram_en, 0);
    idle();
    chk("solo_state", dbg_state, 0);
    chk("solo_rsp_off", rsp1_valid, 0);

    // Write then read same address on consecutive cycles
    set_in(1'b1, 1'b1, 10'h005, 16'h1234, 1'b0, 1'b0, 10'h0, 16'h0);
    chk("wr_ready0", req0_ready, 1);
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, 10'h005);
    chk("wr_ram_di", ram_di, 16'h1234);
    set_in(1'b1, 1'b0, 10'h005, 16'h0, 1'b0, 1'b0, 10'h0, 16'h0);
    chk("rd_ready0", req0_ready, 1);
    chk("rd_ram_we", ram_we, 0);
    chk("wr_no_rsp", rsp0_valid, 0);
    idle();
    chk("rd_rsp0_v", rsp0_valid, 1);
    chk("rd_rsp0_d", rsp0_rdata, 16'h1234);
    chk("rd_rsp1_v", rsp1_valid, 0);

    // Reset right after a read accept discards the response
    set_in(1'b1, 1'b0, 10'h005, 16'h0, 1'b0, 1'b0, 10'h0, 16'h0);
    chk("mid_ready0", req0_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rsp0", rsp0_valid, 0);
    chk("mid_rsp0_d", rsp0_rdata, 0);
    set_in(1'b1, 1'b0, 10'h010, 16'h0, 1'b1, 1'b0, 10'h020, 16'h0);
    chk("mid_ready0_rst", req0_ready, 0);
    chk("mid_ready1_rst", req1_ready, 0);
    chk("mid_rsp0_rst", rsp0_valid, 0);
    set_in(1'b1, 1'b0, 10'h010, 16'h0, 1'b1, 1'b0, 10'h020, 16'h0);
    rst_n = 1'b1;
    #1;
    chk("mid_state", dbg_state, 0);
    chk("mid_prio0", req0_ready, 1);
    chk("mid_prio1", req1_ready, 0);
    set_in(1'b0, 1'b0, 10'h0, 16'h0, 1'b1, 1'b0, 10'h020, 16'h0);
    chk("mid_ready1", req1_ready, 1);
    chk("mid_rsp0_d2", rsp0_rdata, 16'hAAAA);
    idle();
    chk("mid_rsp1_d", rsp1_rdata, 16'h5555);

`ifdef SP_RAM_ARB_STATS_EN
    stats_clr = 1'b1;
    idle();
    stats_clr = 1'b0;
    for (int i = 0; i < 5; i++) set_in(1'b1, 1'b0, 10'(i), 16'h0, 1'b0, 1'b0, 10'h0, 16'h0);
    for (int i = 0; i < 3; i++) set_in(1'b0, 1'b0, 10'h0, 16'h0, 1'b1, 1'b0, 10'(i), 16'h0);
    idle();
    chk("stats_cnt0", gnt0_cnt, 5);
    chk("stats_cnt1", gnt1_cnt, 3);
    set_in(1'b1, 1'b1, 10'h3FF, 16'h0, 1'b0, 1'b0, 10'h0, 16'h0);
    stats_clr = 1'b1;
    #1;
    chk("stats_clr_acc", req0_ready, 1);
    idle();
    stats_clr = 1'b0;
    chk("stats_clr0", gnt0_cnt, 0);
    chk("stats_clr1", gnt1_cnt, 0);
`endif

    idle();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
